// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the 7-segment scan display
// Contents: blank/off patterns, digit index width, BCD pattern table, snapshot type.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] COM_OFF   = 4'b1111;
  localparam int         IDX_W     = 2;

  // Active-low {g,f,e,d,c,b,a} patterns for BCD 0..9.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // One frame's worth of digits, captured together so a frame never tears.
  typedef struct packed {
    logic [2:0] hr_ten;
    logic [3:0] hr_one;
    logic [2:0] min_ten;
    logic [3:0] min_one;
  } digits_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-low 7-segment pattern
// Ports:
//   bcd  in  4  BCD digit; 10..15 decode to blank
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - 4-digit multiplexed common-anode 7-segment scanner
// Optional feature macro: SEG_SCAN_BLINK_EN (blinking colon on dp in the hr_one slot).
// Ports:
//   clk      in  1  system clock
//   rst      in  1  asynchronous reset, active-low
//   disp_en  in  1  1 = display on, 0 = all digits dark
//   hr_ten   in  3  hour tens (BCD 0..2)
//   hr_one   in  4  hour units (BCD 0..9)
//   min_ten  in  3  minute tens (BCD 0..5)
//   min_one  in  4  minute units (BCD 0..9)
//   seg      out 7  {g,f,e,d,c,b,a}, active-low, registered
//   com      out 4  digit enables, active-low; [0]=min_one .. [3]=hr_ten
//   dp       out 1  decimal point/colon, active-low
module seg_scan_display #(
  parameter int SCAN_DIV    = 50000,
  parameter int LZ_SUPPRESS = 1
`ifdef SEG_SCAN_BLINK_EN
  , parameter int BLINK_DIV = 25000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_en,
  input  logic [2:0] hr_ten,
  input  logic [3:0] hr_one,
  input  logic [2:0] min_ten,
  input  logic [3:0] min_one,
  output logic [6:0] seg,
  output logic [3:0] com,
  output logic       dp
);
  import seg_pkg::*;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  digits_t          snap;
  logic             tick;
  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_nxt;

  assign tick = (presc == PW'(SCAN_DIV - 1));

  // Digit mux reads the frame snapshot, never the live inputs.
  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      2'd0: cur_digit = snap.min_one;
      2'd1: cur_digit = {1'b0, snap.min_ten};
      2'd2: cur_digit = snap.hr_one;
      2'd3: cur_digit = {1'b0, snap.hr_ten};
      default: cur_digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Leading-zero blanking only touches the segments; the digit stays selected.
  always_comb begin
    seg_nxt = dec_seg;
    if ((LZ_SUPPRESS != 0) && (idx == 2'd3) && (snap.hr_ten == 3'd0)) seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= '0;
      snap  <= '0;
      seg   <= SEG_BLANK;
      com   <= COM_OFF;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        seg <= seg_nxt;
        idx <= idx + 1'b1;
        // Capture on the last slot so the whole next frame sees one consistent time.
        if (idx == 2'd3) snap <= {hr_ten, hr_one, min_ten, min_one};
      end
      // Blanking is immediate, while scan position keeps advancing underneath.
      if (!disp_en)  com <= COM_OFF;
      else if (tick) com <= ~(4'b0001 << idx);
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] bcnt;
  logic          phase;
  logic          dp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
      dp_q  <= 1'b1;
    end else begin
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
      if (!disp_en)  dp_q <= 1'b1;
      else if (tick) dp_q <= ~((idx == 2'd2) && phase);
    end
  end

  assign dp = dp_q;
`else
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - directed self-checking bench for seg_scan_display
module tb_seg_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       disp_en = 1'b1;
  logic [2:0] hr_ten = 3'd1;
  logic [3:0] hr_one = 4'd2;
  logic [2:0] min_ten = 3'd3;
  logic [3:0] min_one = 4'd4;
  logic [6:0] seg, seg_nlz;
  logic [3:0] com, com_nlz;
  logic       dp, dp_nlz;

  int n_cmp = 0;
  int n_fail = 0;

  seg_scan_display #(.SCAN_DIV(4), .LZ_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .disp_en(disp_en),
    .hr_ten(hr_ten), .hr_one(hr_one), .min_ten(min_ten), .min_one(min_one),
    .seg(seg), .com(com), .dp(dp)
  );

  seg_scan_display #(.SCAN_DIV(4), .LZ_SUPPRESS(0)) dut_nlz (
    .clk(clk), .rst(rst), .disp_en(disp_en),
    .hr_ten(hr_ten), .hr_one(hr_one), .min_ten(min_ten), .min_one(min_one),
    .seg(seg_nlz), .com(com_nlz), .dp(dp_nlz)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    edges(2);
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", seg, 7'b1111111); end n_cmp++;
    if (com !== 4'b1111) begin n_fail++; $display("FAIL reset_com got=%b exp=%b", com, 4'b1111); end n_cmp++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b exp=%b", dp, 1'b1); end n_cmp++;
    @(negedge clk);
    rst = 1'b1;
    edges(3);
    if (com !== 4'b1111) begin n_fail++; $display("FAIL first_tick_early com=%b exp=%b", com, 4'b1111); end n_cmp++;
    edges(1);
    if (com !== 4'b1110) begin n_fail++; $display("FAIL first_tick_com com=%b exp=%b", com, 4'b1110); end n_cmp++;
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL first_tick_seg seg=%b exp=%b", seg, 7'b1000000); end n_cmp++;
  endtask

  task automatic test_scan;
    logic [3:0] exp_com [4];
    logic [6:0] exp_seg [4];
    exp_com = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int i = 1; i < 4; i++) begin
      edges(4);
      if (com !== exp_com[i]) begin n_fail++; $display("FAIL frame1_com%0d com=%b exp=%b", i, com, exp_com[i]); end n_cmp++;
    end
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL frame1_lz seg=%b exp=%b", seg, 7'b1111111); end n_cmp++;
    if (seg_nlz !== 7'b1000000) begin n_fail++; $display("FAIL frame1_nolz seg=%b exp=%b", seg_nlz, 7'b1000000); end n_cmp++;
    for (int i = 0; i < 4; i++) begin
      edges(2);
      if (com !== exp_com[(i + 3) % 4]) begin n_fail++; $display("FAIL hold_com%0d com=%b exp=%b", i, com, exp_com[(i + 3) % 4]); end n_cmp++;
      edges(2);
      if (com !== exp_com[i]) begin n_fail++; $display("FAIL frame2_com%0d com=%b exp=%b", i, com, exp_com[i]); end n_cmp++;
      if (seg !== exp_seg[i]) begin n_fail++; $display("FAIL frame2_seg%0d seg=%b exp=%b", i, seg, exp_seg[i]); end n_cmp++;
      if (dp !== 1'b1) begin n_fail++; $display("FAIL frame2_dp%0d dp=%b exp=%b", i, dp, 1'b1); end n_cmp++;
    end
  endtask

  task automatic test_leading_zero;
    hr_ten = 3'd0;
    hr_one = 4'd9;
    edges(28);
    if (seg !== 7'b0010000) begin n_fail++; $display("FAIL lz_hr_one seg=%b exp=%b", seg, 7'b0010000); end n_cmp++;
    edges(4);
    if (com !== 4'b0111) begin n_fail++; $display("FAIL lz_com com=%b exp=%b", com, 4'b0111); end n_cmp++;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL lz_blank seg=%b exp=%b", seg, 7'b1111111); end n_cmp++;
    if (seg_nlz !== 7'b1000000) begin n_fail++; $display("FAIL lz_off seg=%b exp=%b", seg_nlz, 7'b1000000); end n_cmp++;
  endtask

  task automatic test_snapshot;
    edges(4);
    if (seg !== 7'b0011001) begin n_fail++; $display("FAIL snap_old_one seg=%b exp=%b", seg, 7'b0011001); end n_cmp++;
    min_one = 4'd7;
    min_ten = 3'd5;
    edges(4);
    if (seg !== 7'b0110000) begin n_fail++; $display("FAIL snap_midframe seg=%b exp=%b", seg, 7'b0110000); end n_cmp++;
    edges(12);
    if (com !== 4'b1110) begin n_fail++; $display("FAIL snap_new_com com=%b exp=%b", com, 4'b1110); end n_cmp++;
    if (seg !== 7'b1111000) begin n_fail++; $display("FAIL snap_new_one seg=%b exp=%b", seg, 7'b1111000); end n_cmp++;
    edges(4);
    if (seg !== 7'b0010010) begin n_fail++; $display("FAIL snap_new_ten seg=%b exp=%b", seg, 7'b0010010); end n_cmp++;
  endtask

  task automatic test_invalid_bcd;
    min_one = 4'hC;
    edges(12);
    if (com !== 4'b1110) begin n_fail++; $display("FAIL bad_bcd_com com=%b exp=%b", com, 4'b1110); end n_cmp++;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL bad_bcd_seg seg=%b exp=%b", seg, 7'b1111111); end n_cmp++;
  endtask

  task automatic test_disp_en;
    edges(1);
    disp_en = 1'b0;
    edges(1);
    if (com !== 4'b1111) begin n_fail++; $display("FAIL dis_immediate com=%b exp=%b", com, 4'b1111); end n_cmp++;
    edges(6);
    if (com !== 4'b1111) begin n_fail++; $display("FAIL dis_on_tick com=%b exp=%b", com, 4'b1111); end n_cmp++;
    if (com_nlz !== 4'b1111) begin n_fail++; $display("FAIL dis_on_tick_nlz com=%b exp=%b", com_nlz, 4'b1111); end n_cmp++;
    edges(1);
    disp_en = 1'b1;
    edges(2);
    if (com !== 4'b1111) begin n_fail++; $display("FAIL en_before_tick com=%b exp=%b", com, 4'b1111); end n_cmp++;
    edges(1);
    if (com !== 4'b0111) begin n_fail++; $display("FAIL en_resume_com com=%b exp=%b", com, 4'b0111); end n_cmp++;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL en_resume_seg seg=%b exp=%b", seg, 7'b1111111); end n_cmp++;
    if (seg_nlz !== 7'b1000000) begin n_fail++; $display("FAIL en_resume_nlz seg=%b exp=%b", seg_nlz, 7'b1000000); end n_cmp++;
  endtask

  task automatic test_reset_midframe;
    edges(8);
    if (com !== 4'b1101) begin n_fail++; $display("FAIL pre_rst_com com=%b exp=%b", com, 4'b1101); end n_cmp++;
    #2;
    rst = 1'b0;
    #1;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL async_rst_seg seg=%b exp=%b", seg, 7'b1111111); end n_cmp++;
    if (com !== 4'b1111) begin n_fail++; $display("FAIL async_rst_com com=%b exp=%b", com, 4'b1111); end n_cmp++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL async_rst_dp dp=%b exp=%b", dp, 1'b1); end n_cmp++;
    @(negedge clk);
    rst = 1'b1;
    edges(3);
    if (com !== 4'b1111) begin n_fail++; $display("FAIL rst_release_early com=%b exp=%b", com, 4'b1111); end n_cmp++;
    edges(1);
    if (com !== 4'b1110) begin n_fail++; $display("FAIL rst_release_com com=%b exp=%b", com, 4'b1110); end n_cmp++;
    if (seg !== 7'b1000000) begin n_fail++; $display("FAIL rst_release_seg seg=%b exp=%b", seg, 7'b1000000); end n_cmp++;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_leading_zero;
    test_snapshot;
    test_invalid_bcd;
    test_disp_en;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
